// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file geometry for the write-back scheduler and its helpers.
package regfile_ctrl_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves to the winner on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] grant_idx;
  logic             found;
  int unsigned      idx;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found            = 1'b1;
        grant[PTR_W'(idx)] = 1'b1;
        grant_idx        = PTR_W'(idx);
      end
    end
  end

  // Reset parks the pointer on the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter, registered write port and busy scoreboard for the register file.
import regfile_ctrl_pkg::*;

module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W  = regfile_ctrl_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_address,
  output logic [DATA_W-1:0]         rf_data_to_write,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  output logic                      reserve_ready,
  input  logic [ADDR_W-1:0]         query_addr_0,
  input  logic [ADDR_W-1:0]         query_addr_1,
  output logic                      query_busy_0,
  output logic                      query_busy_1,
  output logic [2**ADDR_W-1:0]      busy_vector
);
  localparam int N_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0] grant;
  logic               xfer_p0;
  logic               wb_live_p0;
  logic [ADDR_W-1:0]  sel_addr_p0;
  logic [DATA_W-1:0]  sel_data_p0;
  logic [N_REGS-1:0]  busy;
  logic [N_REGS-1:0]  clr_vec;
  logic [N_REGS-1:0]  set_vec;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer_p0),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign xfer_p0   = |grant;

  // Grant is one-hot, so an OR-mux selects the winning slice.
  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr_p0 = sel_addr_p0 | req_addr[i*ADDR_W +: ADDR_W];
        sel_data_p0 = sel_data_p0 | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wb_live_p0 = xfer_p0 && (sel_addr_p0 != ZERO_A);

  always_comb begin
    clr_vec = '0;
    if (wb_live_p0) clr_vec[sel_addr_p0] = 1'b1;
  end

  // A claim on a register whose write-back lands this edge is safe to accept.
  assign reserve_ready = reserve_valid &&
                         (!busy[reserve_addr] || clr_vec[reserve_addr] || (reserve_addr == ZERO_A));

  always_comb begin
    set_vec = '0;
    if (reserve_ready && (reserve_addr != ZERO_A)) set_vec[reserve_addr] = 1'b1;
  end

  // ---- stage p0 -> p1: write port register and scoreboard update ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_data_to_write <= '0;
      busy             <= '0;
    end else begin
      rf_write_enable <= wb_live_p0;
      if (xfer_p0) begin
        rf_write_address <= sel_addr_p0;
        rf_data_to_write <= sel_data_p0;
      end
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  // The strobe term covers the half cycle before the negedge write lands.
  assign query_busy_0 = busy[query_addr_0] ||
                        (rf_write_enable && (rf_write_address == query_addr_0) && (query_addr_0 != ZERO_A));
  assign query_busy_1 = busy[query_addr_1] ||
                        (rf_write_enable && (rf_write_address == query_addr_1) && (query_addr_1 != ZERO_A));
  assign busy_vector  = busy;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a cycle-level reference model.
module tb_regfile_wb_scheduler;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             rf_write_enable;
  logic [AW-1:0]    rf_write_address;
  logic [DW-1:0]    rf_data_to_write;
  logic             reserve_valid = 1'b0;
  logic [AW-1:0]    reserve_addr = '0;
  logic             reserve_ready;
  logic [AW-1:0]    query_addr_0 = '0;
  logic [AW-1:0]    query_addr_1 = '0;
  logic             query_busy_0;
  logic             query_busy_1;
  logic [31:0]      busy_vector;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_data_to_write (rf_data_to_write),
    .reserve_valid    (reserve_valid),
    .reserve_addr     (reserve_addr),
    .reserve_ready    (reserve_ready),
    .query_addr_0     (query_addr_0),
    .query_addr_1     (query_addr_1),
    .query_busy_0     (query_busy_0),
    .query_busy_1     (query_busy_1),
    .busy_vector      (busy_vector)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which registers are owed a write, what sits on the write port, who won last.
  bit          m_busy [32];
  bit          m_we   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_last = NR - 1;

  function automatic int model_grant(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit model_res_ok(input logic [NR-1:0] v, input int last,
                                      input logic [4:0] ra, input logic [NR*AW-1:0] addrs);
    int g;
    logic [4:0] wa;
    g = model_grant(v, last);
    wa = (g >= 0) ? addrs[g*AW +: AW] : 5'd0;
    if (ra == 5'd0) return 1'b1;
    if (!m_busy[ra]) return 1'b1;
    return (g >= 0) && (wa == ra);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_last = NR - 1;
    end else begin
      int g;
      bit acc;
      logic [4:0] wa;
      g   = model_grant(req_valid, m_last);
      acc = reserve_valid && model_res_ok(req_valid, m_last, reserve_addr, req_addr);
      m_we = 1'b0;
      if (g >= 0) begin
        wa     = req_addr[g*AW +: AW];
        m_addr = wa;
        m_data = req_data[g*DW +: DW];
        m_we   = (wa != 5'd0);
        if (wa != 5'd0) m_busy[wa] = 1'b0;
        m_last = g;
      end
      if (acc && reserve_addr != 5'd0) m_busy[reserve_addr] = 1'b1;
    end
  end

  // Every negedge: all outputs against the model.
  always @(negedge clk) begin
    int g;
    logic [NR-1:0] eg;
    logic [31:0] ebv;
    g = model_grant(req_valid, m_last);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    ebv = '0;
    for (int i = 0; i < 32; i++) ebv[i] = m_busy[i];
    check("req_ready", 64'(req_ready), 64'(eg));
    check("reserve_ready", 64'(reserve_ready),
          64'(reserve_valid && model_res_ok(req_valid, m_last, reserve_addr, req_addr)));
    check("rf_we", 64'(rf_write_enable), 64'(m_we));
    check("rf_addr", 64'(rf_write_address), 64'(m_addr));
    check("rf_data", 64'(rf_data_to_write), 64'(m_data));
    check("busy_vector", 64'(busy_vector), 64'(ebv));
    check("query_busy_0", 64'(query_busy_0),
          64'(m_busy[query_addr_0] || (m_we && m_addr == query_addr_0 && query_addr_0 != 0)));
    check("query_busy_1", 64'(query_busy_1),
          64'(m_busy[query_addr_1] || (m_we && m_addr == query_addr_1 && query_addr_1 != 0)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    #1;
    check("rst_we", 64'(rf_write_enable), 64'd0);
    check("rst_busy", 64'(busy_vector), 64'd0);
    #11 rst = 1'b1;
    tick();

    // Single write-back from producer 1.
    req_valid = 3'b010; set_req(1, 5'd7, 32'hDEADBEEF);
    @(negedge clk); check("t1_ready", 64'(req_ready), 64'b010);
    tick(); req_valid = '0;
    @(negedge clk);
    check("t1_we", 64'(rf_write_enable), 64'd1);
    check("t1_addr", 64'(rf_write_address), 64'd7);
    check("t1_data", 64'(rf_data_to_write), 64'hDEADBEEF);
    check("t1_busy7", 64'(busy_vector[7]), 64'd0);

    // Producer 2 wins once so the pointer rests on 2.
    tick(); req_valid = 3'b100; set_req(2, 5'd3, 32'h33);
    tick(); req_valid = '0;

    // All three continuously valid.
    tick();
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      int gi;
      @(negedge clk);
      gi = -1;
      for (int k = 0; k < NR; k++) if (req_ready[k]) gi = k;
      check("rr_seq", 64'(gi), 64'(exp_seq[i]));
      check("rr_onehot", 64'($countones(req_ready)), 64'd1);
      tick();
    end
    req_valid = '0;

    // Reserve 5, then write it back.
    reserve_valid = 1'b1; reserve_addr = 5'd5; query_addr_0 = 5'd5;
    @(negedge clk); check("r5_ready", 64'(reserve_ready), 64'd1);
    tick(); reserve_valid = 1'b0;
    @(negedge clk);
    check("r5_busy", 64'(busy_vector[5]), 64'd1);
    check("r5_query", 64'(query_busy_0), 64'd1);
    req_valid = 3'b001; set_req(0, 5'd5, 32'h55);
    tick(); req_valid = '0;
    @(negedge clk);
    check("wb5_busy", 64'(busy_vector[5]), 64'd0);
    check("wb5_query_inflight", 64'(query_busy_0), 64'd1);
    tick();
    @(negedge clk); check("wb5_query_done", 64'(query_busy_0), 64'd0);

    // WAW stall on 9, then reserve alongside the write-back to 9.
    reserve_valid = 1'b1; reserve_addr = 5'd9; query_addr_1 = 5'd9;
    tick();
    @(negedge clk); check("r9_stall", 64'(reserve_ready), 64'd0);
    tick();
    req_valid = 3'b010; set_req(1, 5'd9, 32'h99);
    @(negedge clk); check("r9_with_wb", 64'(reserve_ready), 64'd1);
    tick(); req_valid = '0; reserve_valid = 1'b0;
    @(negedge clk);
    check("r9_set_wins", 64'(busy_vector[9]), 64'd1);
    check("r9_q1", 64'(query_busy_1), 64'd1);
    req_valid = 3'b100; set_req(2, 5'd9, 32'h999);
    tick(); req_valid = '0;

    // Address 0 write-back and reservation.
    req_valid = 3'b001; set_req(0, 5'd0, 32'h1234);
    @(negedge clk); check("z_ready", 64'(req_ready), 64'b001);
    tick(); req_valid = '0;
    @(negedge clk); check("z_we", 64'(rf_write_enable), 64'd0);
    reserve_valid = 1'b1; reserve_addr = 5'd0;
    @(negedge clk); check("z_res", 64'(reserve_ready), 64'd1);
    tick(); reserve_valid = 1'b0;
    @(negedge clk); check("z_busyvec", 64'(busy_vector), 64'd0);

    // Asynchronous reset with a busy bit, a strobe out and requests pending.
    tick(); reserve_valid = 1'b1; reserve_addr = 5'd12;
    tick(); reserve_valid = 1'b0; req_valid = 3'b100; set_req(2, 5'd4, 32'hAA);
    tick();
    set_req(0, 5'd6, 32'h66); set_req(1, 5'd8, 32'h88); req_valid = 3'b011;
    #1 rst = 1'b0;
    #1;
    check("ar_we", 64'(rf_write_enable), 64'd0);
    check("ar_addr", 64'(rf_write_address), 64'd0);
    check("ar_data", 64'(rf_data_to_write), 64'd0);
    check("ar_busy", 64'(busy_vector), 64'd0);
    check("ar_ready", 64'(req_ready), 64'b001);
    #2 rst = 1'b1;
    tick(); req_valid = '0;
    @(negedge clk);
    check("ar_restart_addr", 64'(rf_write_address), 64'd6);
    check("ar_restart_data", 64'(rf_data_to_write), 64'h66);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
